// File: rtl/scope_capture_ctrl.sv
// rtl/scope_capture_ctrl.sv - oscilloscope capture sequencer: circular pre/post-trigger write and time-ordered readout
module scope_capture_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 14,
  // RAM read latency: 1 (no output register) or 2 (output register)
  parameter int RD_LAT     = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  arm,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] pre_len,
  input  logic                  trig,
  input  logic                  sample_valid,
  input  logic [DATA_WIDTH-1:0] sample_data,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_waddr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  ram_re,
  output logic [ADDR_WIDTH-1:0] ram_raddr,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  busy,
  output logic                  triggered,
  output logic                  done,
  input  logic                  rd_start,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  input  logic                  out_ready
);

  // Skid FIFO holds every read that may be in flight when the consumer stalls
  localparam int FIFO_DEPTH = RD_LAT + 1;
  localparam int PW         = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW         = $clog2(FIFO_DEPTH + 1);

  localparam logic [ADDR_WIDTH:0]   DEPTH_C  = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   C_ONE    = 1;
  localparam logic [ADDR_WIDTH-1:0] A_ONE    = 1;
  localparam logic [PW-1:0]         P_ONE    = 1;
  localparam logic [PW-1:0]         PTR_LAST = PW'(FIFO_DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_WAIT_TRIG,
    S_POST,
    S_DONE,
    S_READ
  } state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] wp_q;
  logic [ADDR_WIDTH-1:0] p_q;
  logic [ADDR_WIDTH-1:0] t_q;
  logic [ADDR_WIDTH-1:0] ra_q;
  logic [ADDR_WIDTH:0]   cnt_q;
  logic [ADDR_WIDTH:0]   issue_cnt_q;
  logic [ADDR_WIDTH:0]   emit_cnt_q;
  logic                  triggered_q;
  logic                  busy_q;
  logic                  done_q;

  logic [RD_LAT-1:0]     tag_q;
  logic [RD_LAT-1:0]     tag_d;
  logic [DATA_WIDTH-1:0] fifo_mem_q [FIFO_DEPTH];
  logic [PW-1:0]         fifo_wptr_q;
  logic [PW-1:0]         fifo_rptr_q;
  logic [CW-1:0]         fifo_cnt_q;

  logic                  writing;
  logic                  wr_en;
  logic                  rd_en;
  logic                  push;
  logic                  pop;
  logic [ADDR_WIDTH:0]   post_len;
  logic [CW:0]           inflight;
  logic [CW:0]           credit_used;

  // Strobe decode: writes follow sample_valid in the capture states, reads are credit-limited
  always_comb begin
    writing     = (state_q == S_PRE) || (state_q == S_WAIT_TRIG) || (state_q == S_POST);
    wr_en       = writing && sample_valid && !abort;
    post_len    = DEPTH_C - {1'b0, p_q};
    inflight    = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight = inflight + (CW+1)'(tag_q[i]);
    end
    pop         = (fifo_cnt_q != '0) && out_ready;
    // A pop this cycle frees a slot, which keeps readout at one sample per cycle
    credit_used = inflight + (CW+1)'(fifo_cnt_q) - (CW+1)'(pop);
    rd_en       = (state_q == S_READ) && !abort && (issue_cnt_q != '0) &&
                  (credit_used < (CW+1)'(FIFO_DEPTH));
    push        = tag_q[RD_LAT-1];
    tag_d       = (tag_q << 1) | RD_LAT'(rd_en);
  end

  assign ram_we    = wr_en;
  assign ram_waddr = wp_q;
  assign ram_wdata = wr_en ? sample_data : '0;
  assign ram_re    = rd_en;
  assign ram_raddr = ra_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign triggered = triggered_q;
  assign out_valid = (fifo_cnt_q != '0);
  assign out_data  = out_valid ? fifo_mem_q[fifo_rptr_q] : '0;
  assign out_last  = out_valid && (emit_cnt_q == C_ONE);

  // Capture/readout sequencer: state, pointers, counters and registered status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wp_q        <= '0;
      p_q         <= '0;
      t_q         <= '0;
      ra_q        <= '0;
      cnt_q       <= '0;
      issue_cnt_q <= '0;
      emit_cnt_q  <= '0;
      triggered_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else if (abort) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      issue_cnt_q <= '0;
      emit_cnt_q  <= '0;
      triggered_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      if (wr_en) begin
        wp_q <= wp_q + A_ONE;
      end
      if (rd_en) begin
        ra_q        <= ra_q + A_ONE;
        issue_cnt_q <= issue_cnt_q - C_ONE;
      end
      if (pop) begin
        emit_cnt_q <= emit_cnt_q - C_ONE;
      end
      case (state_q)
        S_IDLE, S_DONE: begin
          if (arm) begin
            // Re-arming leaves the RAM contents alone; they are overwritten by the new record
            p_q         <= pre_len;
            wp_q        <= '0;
            cnt_q       <= '0;
            triggered_q <= 1'b0;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            state_q     <= (pre_len == '0) ? S_WAIT_TRIG : S_PRE;
          end else if ((state_q == S_DONE) && rd_start) begin
            // Oldest retained sample sits P entries before the trigger sample
            ra_q        <= t_q - p_q;
            issue_cnt_q <= DEPTH_C;
            emit_cnt_q  <= DEPTH_C;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            state_q     <= S_READ;
          end
        end
        S_PRE: begin
          if (wr_en) begin
            cnt_q <= cnt_q + C_ONE;
            if ((cnt_q + C_ONE) == {1'b0, p_q}) begin
              state_q <= S_WAIT_TRIG;
            end
          end
        end
        S_WAIT_TRIG: begin
          if (wr_en && trig) begin
            // The trigger sample itself is post sample 1
            t_q         <= wp_q;
            triggered_q <= 1'b1;
            cnt_q       <= C_ONE;
            if (post_len == C_ONE) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_POST;
            end
          end
        end
        S_POST: begin
          if (wr_en) begin
            cnt_q <= cnt_q + C_ONE;
            if ((cnt_q + C_ONE) == post_len) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        S_READ: begin
          if (pop && (emit_cnt_q == C_ONE)) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // Read-latency tag pipeline and skid FIFO pointers; abort discards everything in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q       <= '0;
      fifo_wptr_q <= '0;
      fifo_rptr_q <= '0;
      fifo_cnt_q  <= '0;
    end else if (abort) begin
      tag_q       <= '0;
      fifo_wptr_q <= '0;
      fifo_rptr_q <= '0;
      fifo_cnt_q  <= '0;
    end else begin
      tag_q <= tag_d;
      if (push) begin
        fifo_wptr_q <= (fifo_wptr_q == PTR_LAST) ? '0 : fifo_wptr_q + P_ONE;
      end
      if (pop) begin
        fifo_rptr_q <= (fifo_rptr_q == PTR_LAST) ? '0 : fifo_rptr_q + P_ONE;
      end
      fifo_cnt_q <= fifo_cnt_q + CW'(push) - CW'(pop);
    end
  end

  // Skid FIFO storage; contents are only visible through the occupancy-gated head
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem_q[fifo_wptr_q] <= ram_rdata;
    end
  end

endmodule

// File: tb/tb_scope_capture_ctrl.sv
// tb/tb_scope_capture_ctrl.sv - self-checking bench for scope_capture_ctrl at RD_LAT 1 and 2
module tb_scope_capture_ctrl;

  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          arm;
  logic          abort;
  logic [AW-1:0] pre_len;
  logic          trig;
  logic          sample_valid;
  logic [DW-1:0] sample_data;
  logic          rd_start;
  logic          out_ready;

  logic [1:0]         ram_we, ram_re, busy, triggered, done, out_valid, out_last;
  logic [1:0][AW-1:0] ram_waddr, ram_raddr;
  logic [1:0][DW-1:0] ram_wdata, ram_rdata, out_data;

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] hist [$];
  logic [DW-1:0] exp_rec [DEPTH];

  // Two DUTs share all stimulus; instance g uses RD_LAT = g+1 with a matching RAM model
  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rd_s1;
    logic [DW-1:0] rd_s2;
    always @(posedge clk) begin
      if (ram_we[g]) mem[ram_waddr[g]] <= ram_wdata[g];
      if (ram_re[g]) rd_s1 <= mem[ram_raddr[g]];
      rd_s2 <= rd_s1;
    end
    assign ram_rdata[g] = (g == 0) ? rd_s1 : rd_s2;

    scope_capture_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LAT(g + 1)) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .arm         (arm),
      .abort       (abort),
      .pre_len     (pre_len),
      .trig        (trig),
      .sample_valid(sample_valid),
      .sample_data (sample_data),
      .ram_we      (ram_we[g]),
      .ram_waddr   (ram_waddr[g]),
      .ram_wdata   (ram_wdata[g]),
      .ram_re      (ram_re[g]),
      .ram_raddr   (ram_raddr[g]),
      .ram_rdata   (ram_rdata[g]),
      .busy        (busy[g]),
      .triggered   (triggered[g]),
      .done        (done[g]),
      .rd_start    (rd_start),
      .out_valid   (out_valid[g]),
      .out_data    (out_data[g]),
      .out_last    (out_last[g]),
      .out_ready   (out_ready)
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    arm          = 1'b0;
    abort        = 1'b0;
    rd_start     = 1'b0;
    trig         = 1'b0;
    sample_valid = 1'b0;
    out_ready    = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_we"}, 32'(ram_we), 0);
    chk({tag, "_re"}, 32'(ram_re), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_trig"}, 32'(triggered), 0);
    chk({tag, "_ovalid"}, 32'(out_valid), 0);
    chk({tag, "_olast"}, 32'(out_last), 0);
    chk({tag, "_odata"}, {out_data[1], out_data[0]}, 0);
    chk({tag, "_waddr"}, 32'({ram_waddr[1], ram_waddr[0]}), 0);
    chk({tag, "_raddr"}, 32'({ram_raddr[1], ram_raddr[0]}), 0);
    chk({tag, "_wdata"}, {ram_wdata[1], ram_wdata[0]}, 0);
  endtask

  // Record model: after arm, the record is the DEPTH accepted samples starting P before the trigger
  task automatic run_capture(input int p, input int tidx, input bit ramp, input bit dense,
                             input int abort_at);
    int            n;
    int            total;
    int            cyc;
    bit            sv;
    bit            aborted;
    logic [DW-1:0] d;
    hist.delete();
    @(negedge clk);
    idle_inputs();
    arm     = 1'b1;
    pre_len = p[AW-1:0];
    #1;
    chk("arm_cycle_we", 32'(ram_we), 0);
    n       = 0;
    total   = tidx + DEPTH - p;
    cyc     = 0;
    aborted = 1'b0;
    while (n < total && cyc < 4000 && !aborted) begin
      @(negedge clk);
      idle_inputs();
      sv          = dense || ($urandom_range(0, 3) != 0);
      d           = ramp ? DW'(n) : DW'($urandom);
      sample_data = d;
      if (sv) trig = (n == tidx) || ((n < p) && ($urandom_range(0, 1) == 1));
      else    trig = ($urandom_range(0, 1) == 1);
      arm      = ($urandom_range(0, 15) == 0);
      rd_start = ($urandom_range(0, 15) == 0);
      if (n == abort_at) begin
        sv    = 1'b1;
        abort = 1'b1;
        arm   = 1'b1;
      end
      sample_valid = sv;
      #1;
      if (abort) begin
        @(negedge clk);
        idle_inputs();
        sample_valid = 1'b1;
        #1;
        chk("abort_post_we", 32'(ram_we), 0);
        chk("abort_post_busy", 32'(busy), 0);
        chk("abort_post_done", 32'(done), 0);
        chk("abort_post_trig", 32'(triggered), 0);
        aborted = 1'b1;
      end else begin
        chk("cap_we", 32'(ram_we), {30'd0, sv, sv});
        if (sv) begin
          chk("cap_waddr", 32'({ram_waddr[1], ram_waddr[0]}), 32'({2{n[AW-1:0]}}));
          chk("cap_wdata", {ram_wdata[1], ram_wdata[0]}, {d, d});
          hist.push_back(d);
          n++;
        end
        chk("cap_busy", 32'(busy), 3);
        chk("cap_done", 32'(done), 0);
        chk("cap_trig", 32'(triggered), 32'({2{((n - (sv ? 1 : 0)) > tidx)}}));
      end
      cyc++;
    end
    if (!aborted) begin
      if (n < total) chk("capture_timeout", 32'(n), 32'(total));
      @(negedge clk);
      idle_inputs();
      sample_valid = 1'b1;
      sample_data  = DW'($urandom);
      trig         = 1'b1;
      #1;
      chk("done_flag", 32'(done), 3);
      chk("done_busy", 32'(busy), 0);
      chk("done_trig", 32'(triggered), 3);
      chk("done_we", 32'(ram_we), 0);
      for (int i = 0; i < DEPTH; i++) exp_rec[i] = hist[tidx - p + i];
    end
  endtask

  // mode 0: ready held 1; 1: random ready; 2: stall then abort; 3: random ready then reset
  task automatic run_readout(input int mode);
    int            idx [2];
    int            first [2];
    int            lastc [2];
    bit            hold [2];
    logic [DW-1:0] hd [2];
    int            cyc;
    bit            ended;
    for (int k = 0; k < 2; k++) begin
      idx[k] = 0; first[k] = -1; lastc[k] = -1; hold[k] = 1'b0; hd[k] = '0;
    end
    @(negedge clk);
    idle_inputs();
    rd_start = 1'b1;
    #1;
    chk("rd_start_ovalid", 32'(out_valid), 0);
    cyc   = 0;
    ended = 1'b0;
    while ((idx[0] < DEPTH || idx[1] < DEPTH) && cyc < 600 && !ended) begin
      @(negedge clk);
      idle_inputs();
      case (mode)
        0:       out_ready = 1'b1;
        2:       out_ready = 1'b0;
        default: out_ready = ($urandom_range(0, 1) == 1);
      endcase
      sample_valid = ($urandom_range(0, 1) == 1);
      sample_data  = DW'($urandom);
      rd_start     = ($urandom_range(0, 7) == 0);
      arm          = (idx[0] < DEPTH) && (idx[1] < DEPTH) && ($urandom_range(0, 7) == 0);
      pre_len      = AW'($urandom);
      #1;
      chk("rd_we", 32'(ram_we), 0);
      for (int k = 0; k < 2; k++) begin
        if (idx[k] < DEPTH) begin
          if (hold[k]) begin
            chk("hold_valid", 32'(out_valid[k]), 1);
            chk("hold_data", 32'(out_data[k]), 32'(hd[k]));
          end
          if (out_valid[k]) begin
            if (first[k] < 0) first[k] = cyc;
            if (out_ready) begin
              chk("rd_data", 32'(out_data[k]), 32'(exp_rec[idx[k]]));
              chk("rd_last", 32'(out_last[k]), 32'(idx[k] == DEPTH - 1));
              idx[k]++;
              lastc[k] = cyc;
            end
          end
          hold[k] = out_valid[k] && !out_ready;
          hd[k]   = out_data[k];
        end else begin
          chk("after_last_valid", 32'(out_valid[k]), 0);
          chk("after_last_busy", 32'(busy[k]), 0);
        end
      end
      if (mode == 2 && cyc == 5) begin
        chk("stall_full_valid", 32'(out_valid), 3);
        chk("stall_no_issue", 32'(ram_re), 0);
      end
      if (mode == 2 && cyc == 6) begin
        @(negedge clk);
        idle_inputs();
        abort = 1'b1; arm = 1'b1; rd_start = 1'b1; out_ready = 1'b1;
        #1;
        @(negedge clk);
        idle_inputs();
        sample_valid = 1'b1;
        out_ready    = 1'b1;
        #1;
        chk("abort_rd_valid", 32'(out_valid), 0);
        chk("abort_rd_re", 32'(ram_re), 0);
        chk("abort_rd_we", 32'(ram_we), 0);
        chk("abort_rd_busy", 32'(busy), 0);
        chk("abort_rd_trig", 32'(triggered), 0);
        chk("abort_rd_done", 32'(done), 0);
        ended = 1'b1;
      end
      if (mode == 3 && cyc == 10) begin
        rst_n        = 1'b0;
        sample_valid = 1'b1;
        #1;
        chk_all_zero("rst_mid_read");
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;
        ended = 1'b1;
      end
      cyc++;
    end
    if (!ended) begin
      chk("rd_count0", 32'(idx[0]), DEPTH);
      chk("rd_count1", 32'(idx[1]), DEPTH);
      if (mode == 0) begin
        chk("throughput0", 32'(lastc[0] - first[0] + 1), DEPTH);
        chk("throughput1", 32'(lastc[1] - first[1] + 1), DEPTH);
      end
      @(negedge clk);
      idle_inputs();
      #1;
      chk("rd_end_busy", 32'(busy), 0);
      chk("rd_end_done", 32'(done), 0);
      chk("rd_end_trig", 32'(triggered), 3);
      chk("rd_end_valid", 32'(out_valid), 0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    int t;
    rst_n       = 1'b0;
    idle_inputs();
    pre_len     = '0;
    sample_data = 16'h1234;
    repeat (3) @(negedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    run_capture(4, 10, 1'b1, 1'b1, -1);
    run_readout(0);

    p = $urandom_range(1, 14);
    t = p + $urandom_range(0, 20);
    run_capture(p, t, 1'b0, 1'b0, -1);
    run_readout(1);

    run_capture(0, 3, 1'b0, 1'b0, -1);
    run_readout(1);

    run_capture(15, 15, 1'b0, 1'b0, -1);
    run_readout(1);

    run_capture(15, 22, 1'b1, 1'b0, -1);
    run_readout(1);

    run_capture(4, 44, 1'b1, 1'b0, -1);
    run_readout(1);

    run_capture(6, 8, 1'b0, 1'b0, 12);

    run_capture(5, 9, 1'b0, 1'b0, -1);
    run_readout(2);

    run_capture(5, 9, 1'b1, 1'b0, -1);
    run_readout(0);

    run_capture(7, 12, 1'b0, 1'b0, -1);
    run_readout(3);

    run_capture(3, 7, 1'b0, 1'b0, -1);
    run_readout(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
